booth4_seq: RTL

Operand sequencer and product collector for the radix-4 Booth multiplier (`booth4`). It accepts a signed 8-bit operand pair on a valid/ready handshake and pulses the multiplier's `enable`. It drives the multiplicand and then the multiplier byte onto the multiplier's shared `inbus`. It then waits for `done`, captures the two product bytes from `outbus`, and presents a 16-bit signed product on a valid/ready handshake. A watchdog and an optional self-check flag a hung or faulty multiplier.

---
 rtl/booth4_seq_if.sv | 22 ++
 rtl/booth4_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/booth4_seq_if.sv
// Operand-in and product-out handshake bundle for the booth4 operand sequencer.
// The producer/consumer side uses master; the sequencer uses slave.
interface booth4_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_mismatch;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, out_mismatch
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, out_mismatch
    );
endinterface

// File: rtl/booth4_seq.sv
// Sequencer for the radix-4 Booth multiplier: feeds M then Q over the shared inbus,
// collects the two product bytes after done, and presents a checked 16-bit product.
module booth4_seq #(
    parameter int unsigned M_SLOT  = 1,
    parameter int unsigned Q_SLOT  = 2,
    parameter int unsigned HI_SLOT = 1,
    parameter int unsigned LO_SLOT = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter bit          CHECK   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    booth4_seq_if.slave io,
    output logic        mul_enable,
    output logic [7:0]  mul_inbus,
    input  logic        mul_done,
    input  logic [7:0]  mul_outbus,
    output logic        err_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COLLECT = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    localparam int unsigned     WDW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      M_C     = 8'(M_SLOT);
    localparam logic [7:0]      Q_C     = 8'(Q_SLOT);
    localparam logic [7:0]      HI_C    = 8'(HI_SLOT);
    localparam logic [7:0]      LO_C    = 8'(LO_SLOT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0]  WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0]  WD_ZERO = WDW'(0);

    // Full-range signed 8x8 reference product; -128*-128 still fits in 16 bits.
    function automatic logic [15:0] smul8(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] xs;
        logic signed [15:0] ys;
        xs = {{8{x[7]}}, x};
        ys = {{8{y[7]}}, y};
        return xs * ys;
    endfunction

    state_t         state_r, state_nx_s;
    logic [7:0]     a_r, a_nx_s, b_r, b_nx_s;
    logic [7:0]     hi_r, hi_nx_s, lo_r, lo_nx_s;
    logic [7:0]     k_r, k_nx_s, d_r, d_nx_s;
    logic [WDW-1:0] wd_r, wd_nx_s;
    logic           timeout_s;
    logic           mismatch_nx_s;
    logic           enter_out_s;

    logic           in_ready_r, mul_enable_r, out_valid_r, out_mismatch_r;
    logic           err_timeout_r, busy_r;
    logic [7:0]     mul_inbus_r;
    logic [15:0]    out_product_r;

    // Next-state and datapath decisions for the sequencer FSM.
    always_comb begin
        state_nx_s = state_r;
        a_nx_s     = a_r;
        b_nx_s     = b_r;
        hi_nx_s    = hi_r;
        lo_nx_s    = lo_r;
        k_nx_s     = k_r;
        d_nx_s     = d_r;
        wd_nx_s    = wd_r;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (io.in_valid && in_ready_r) begin
                    a_nx_s     = io.in_a;
                    b_nx_s     = io.in_b;
                    k_nx_s     = 8'd0;
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (k_r == Q_C) begin
                    k_nx_s     = 8'd0;
                    wd_nx_s    = WD_ZERO;
                    state_nx_s = ST_WAIT;
                end else begin
                    k_nx_s     = k_r + 8'd1;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    // This cycle is d=0, so a zero hi slot captures here.
                    d_nx_s     = 8'd1;
                    state_nx_s = ST_COLLECT;
                    if (HI_C == 8'd0) begin
                        hi_nx_s = mul_outbus;
                    end else begin
                        hi_nx_s = hi_r;
                    end
                end else if (wd_r == WD_LAST) begin
                    timeout_s  = 1'b1;
                    wd_nx_s    = WD_ZERO;
                    state_nx_s = ST_IDLE;
                end else begin
                    wd_nx_s    = wd_r + WD_ONE;
                end
            end
            ST_COLLECT: begin
                d_nx_s = d_r + 8'd1;
                if (d_r == HI_C) begin
                    hi_nx_s = mul_outbus;
                end else begin
                    hi_nx_s = hi_r;
                end
                if (d_r == LO_C) begin
                    lo_nx_s    = mul_outbus;
                    d_nx_s     = 8'd0;
                    state_nx_s = ST_OUT;
                end else begin
                    lo_nx_s    = lo_r;
                end
            end
            ST_OUT: begin
                if (io.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Product check and OUT-entry detection feed the registered output stage.
    always_comb begin
        enter_out_s   = (state_r != ST_OUT) && (state_nx_s == ST_OUT);
        mismatch_nx_s = 1'b0;
        if (CHECK == 1'b1) begin
            mismatch_nx_s = ({hi_nx_s, lo_nx_s} != smul8(a_r, b_r));
        end else begin
            mismatch_nx_s = 1'b0;
        end
    end

    // FSM state, operand latches, collected bytes and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= 8'd0;
            b_r     <= 8'd0;
            hi_r    <= 8'd0;
            lo_r    <= 8'd0;
            k_r     <= 8'd0;
            d_r     <= 8'd0;
            wd_r    <= WD_ZERO;
        end else begin
            state_r <= state_nx_s;
            a_r     <= a_nx_s;
            b_r     <= b_nx_s;
            hi_r    <= hi_nx_s;
            lo_r    <= lo_nx_s;
            k_r     <= k_nx_s;
            d_r     <= d_nx_s;
            wd_r    <= wd_nx_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r     <= 1'b0;
            mul_enable_r   <= 1'b0;
            mul_inbus_r    <= 8'd0;
            out_valid_r    <= 1'b0;
            out_product_r  <= 16'd0;
            out_mismatch_r <= 1'b0;
            err_timeout_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            in_ready_r    <= (state_nx_s == ST_IDLE);
            mul_enable_r  <= (state_nx_s == ST_LOAD) && (k_nx_s == 8'd0);
            if ((state_nx_s == ST_LOAD) && (k_nx_s == M_C)) begin
                mul_inbus_r <= a_nx_s;
            end else if ((state_nx_s == ST_LOAD) && (k_nx_s == Q_C)) begin
                mul_inbus_r <= b_nx_s;
            end else begin
                mul_inbus_r <= 8'd0;
            end
            out_valid_r   <= (state_nx_s == ST_OUT);
            if (enter_out_s) begin
                out_product_r  <= {hi_nx_s, lo_nx_s};
                out_mismatch_r <= mismatch_nx_s;
            end else begin
                out_product_r  <= out_product_r;
                out_mismatch_r <= out_mismatch_r;
            end
            err_timeout_r <= timeout_s;
            busy_r        <= (state_nx_s != ST_IDLE);
        end
    end

    assign io.in_ready     = in_ready_r;
    assign io.out_valid    = out_valid_r;
    assign io.out_product  = out_product_r;
    assign io.out_mismatch = out_mismatch_r;
    assign mul_enable      = mul_enable_r;
    assign mul_inbus       = mul_inbus_r;
    assign err_timeout     = err_timeout_r;
    assign busy            = busy_r;

endmodule
